// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state, owner and width codes for the RAM port arbiter.
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_MEM} owner_t;
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic Enable = 1'b1;
  localparam logic Disable = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0;
  function automatic logic [2:0] nbytes(input logic [1:0] w);
    return w == W_BYTE ? 3'd1 : w == W_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_port_grant.sv
// mem_port_grant: picks the next RAM port owner; ARB_ROUNDROBIN_EN adds a last-grant register.
module mem_port_grant (
`ifdef ARB_ROUNDROBIN_EN
  input  logic clk,
  input  logic rst_n,
  input  logic take,
`endif
  input  logic req_ic,
  input  logic req_mem,
  output logic gnt_ic,
  output logic gnt_mem
);
`ifdef ARB_ROUNDROBIN_EN
  logic last_mem;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_mem <= 1'b0;
    else if (take && (req_ic || req_mem)) last_mem <= gnt_mem;
  assign gnt_mem = req_mem & (~req_ic | ~last_mem);
`else
  assign gnt_mem = req_mem;
`endif
  assign gnt_ic = req_ic & ~gnt_mem;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises ICACHE fills and MEM loads/stores onto one byte-wide RAM port.
// Optional ARB_ROUNDROBIN_EN swaps fixed MEM priority for alternating priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re_ICACHE_i,
  input  logic [31:0]       addr_ICACHE_i,
  output logic [31:0]       data_ICACHE_o,
  output logic              done_ICACHE_o,
  input  logic              re_MEM_i,
  input  logic              we_MEM_i,
  input  logic [31:0]       addr_MEM_i,
  input  logic [1:0]        width_MEM_i,
  input  logic [31:0]       data_MEM_i,
  output logic [31:0]       data_MEM_o,
  output logic              done_MEM_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i,
  output logic              stall_STALLER_o
);
  state_t state;
  owner_t owner;
  logic [ADDR_W-1:0] base, req_a, nxt_a;
  logic [2:0] n, cnt;
  logic [1:0] rd_lane, wr_lane;
  logic [31:0] wdata, rbuf;
  logic gnt_ic, gnt_mem, unused_hi;
  mem_port_grant u_grant (
`ifdef ARB_ROUNDROBIN_EN
    .clk(clk),
    .rst_n(rst_n),
    .take(state == IDLE),
`endif
    .req_ic(re_ICACHE_i),
    .req_mem(re_MEM_i | we_MEM_i),
    .gnt_ic(gnt_ic),
    .gnt_mem(gnt_mem)
  );
  assign req_a = gnt_mem ? addr_MEM_i[ADDR_W-1:0] : addr_ICACHE_i[ADDR_W-1:0];
  assign nxt_a = base + ADDR_W'(cnt) + ADDR_W'(1);
  // read data for byte k arrives one cycle after its address, so capture lags by one
  assign rd_lane = cnt[1:0] - 2'd1;
  assign wr_lane = cnt[1:0] + 2'd1;
  assign unused_hi = &{1'b0, addr_ICACHE_i[31:ADDR_W], addr_MEM_i[31:ADDR_W]};
  assign data_ICACHE_o = done_ICACHE_o ? rbuf : ZeroWord;
  assign data_MEM_o = done_MEM_o ? rbuf : ZeroWord;
  assign stall_STALLER_o = (re_MEM_i | we_MEM_i) & ~done_MEM_o;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      owner <= OWN_NONE;
      base <= '0;
      n <= '0;
      cnt <= '0;
      wdata <= ZeroWord;
      rbuf <= ZeroWord;
      ram_a_o <= '0;
      ram_dout_o <= '0;
      ram_wr_o <= Disable;
      done_ICACHE_o <= Disable;
      done_MEM_o <= Disable;
    end else begin
      done_ICACHE_o <= Disable;
      done_MEM_o <= Disable;
      case (state)
        IDLE: if (gnt_ic || gnt_mem) begin
          owner <= gnt_mem ? OWN_MEM : OWN_IC;
          base <= req_a;
          ram_a_o <= req_a;
          n <= gnt_mem ? nbytes(width_MEM_i) : 3'(WORD_BYTES);
          wdata <= data_MEM_i;
          rbuf <= ZeroWord;
          cnt <= '0;
          ram_dout_o <= data_MEM_i[7:0];
          ram_wr_o <= gnt_mem & we_MEM_i;
          state <= (gnt_mem && we_MEM_i) ? WR : RD;
        end
        RD: begin
          if (cnt != 3'd0) rbuf[{rd_lane, 3'b000} +: 8] <= ram_din_i;
          if (cnt == n) begin
            state <= DONE;
            done_ICACHE_o <= owner == OWN_IC;
            done_MEM_o <= owner == OWN_MEM;
          end else begin
            if (cnt < n - 3'd1) ram_a_o <= nxt_a;
            cnt <= cnt + 3'd1;
          end
        end
        WR: if (cnt == n - 3'd1) begin
          state <= DONE;
          ram_wr_o <= Disable;
          done_MEM_o <= Enable;
        end else begin
          ram_a_o <= nxt_a;
          ram_dout_o <= wdata[{wr_lane, 3'b000} +: 8];
          cnt <= cnt + 3'd1;
        end
        DONE: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a byte RAM model and a reference memory.
module tb_mem_port_arbiter;
  localparam int AW = 17;
  localparam int MASK = (1 << AW) - 1;
  logic clk = 0, rst_n = 0;
  logic re_ICACHE_i = 0, re_MEM_i = 0, we_MEM_i = 0;
  logic [31:0] addr_ICACHE_i = 0, addr_MEM_i = 0, data_MEM_i = 0;
  logic [1:0] width_MEM_i = 0;
  logic [31:0] data_ICACHE_o, data_MEM_o;
  logic done_ICACHE_o, done_MEM_o, ram_wr_o, stall_STALLER_o;
  logic [AW-1:0] ram_a_o;
  logic [7:0] ram_dout_o, ram_din_i;

  mem_port_arbiter #(.ADDR_W(AW), .WORD_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .re_ICACHE_i(re_ICACHE_i), .addr_ICACHE_i(addr_ICACHE_i),
    .data_ICACHE_o(data_ICACHE_o), .done_ICACHE_o(done_ICACHE_o),
    .re_MEM_i(re_MEM_i), .we_MEM_i(we_MEM_i), .addr_MEM_i(addr_MEM_i),
    .width_MEM_i(width_MEM_i), .data_MEM_i(data_MEM_i),
    .data_MEM_o(data_MEM_o), .done_MEM_o(done_MEM_o),
    .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o),
    .ram_din_i(ram_din_i), .stall_STALLER_o(stall_STALLER_o)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_byte(input int a);
    logic [31:0] h;
    case (a)
      32'h1000: return 8'h13;
      32'h1001: return 8'h05;
      32'h1002: return 8'h10;
      32'h1003: return 8'h00;
      32'h1FFFE: return 8'h11;
      32'h1FFFF: return 8'h22;
      32'h0: return 8'h33;
      32'h1: return 8'h44;
      default: begin
        h = a * 32'h9E3779B1;
        return h[23:16];
      end
    endcase
  endfunction

  // byte RAM: read data appears the cycle after the address
  logic [7:0] ram [0:MASK];
  initial begin
    for (int i = 0; i <= MASK; i++) ram[i] = init_byte(i);
    ram_din_i = 0;
    forever begin
      @(posedge clk);
      ram_din_i <= ram[ram_a_o];
      if (ram_wr_o) ram[ram_a_o] = ram_dout_o;
    end
  end

  logic [7:0] ref_mem [0:MASK];
  typedef struct {logic [31:0] data; bit chk_data; int at;} exp_t;
  exp_t q_ic[$], q_mem[$];
  exp_t e_ic, e_mem;
  bit last_mem = 0;

  always @(negedge clk) if (rst_n) begin
    if (done_ICACHE_o) begin
      chk("ic_pending", 32'(q_ic.size() > 0), 1);
      if (q_ic.size() > 0) begin
        e_ic = q_ic.pop_front();
        chk("ic_data", data_ICACHE_o, e_ic.data);
        if (e_ic.at >= 0) chk("ic_done_cycle", cyc, e_ic.at);
      end
      last_mem = 0;
    end
    if (done_MEM_o) begin
      chk("mem_pending", 32'(q_mem.size() > 0), 1);
      if (q_mem.size() > 0) begin
        e_mem = q_mem.pop_front();
        if (e_mem.chk_data) chk("mem_data", data_MEM_o, e_mem.data);
        if (e_mem.at >= 0) chk("mem_done_cycle", cyc, e_mem.at);
      end
      last_mem = 1;
    end
  end

  task automatic ic_fill(input logic [31:0] a, input int lat);
    exp_t e;
    int start;
    bit ok = 0;
    @(posedge clk);
    #1;
    re_ICACHE_i = 1;
    addr_ICACHE_i = a;
    start = cyc;
    e.data = 0;
    for (int k = 0; k < 4; k++) e.data[8*k +: 8] = ref_mem[(a + k) & MASK];
    e.chk_data = 1;
    e.at = lat < 0 ? -1 : start + lat;
    q_ic.push_back(e);
    repeat (200) begin
      @(negedge clk);
      if (done_ICACHE_o) begin
        ok = 1;
        break;
      end
    end
    chk("ic_done_seen", 32'(ok), 1);
    @(posedge clk);
    #1 re_ICACHE_i = 0;
  endtask

  task automatic mem_op(input bit we, input logic [31:0] a, input logic [1:0] w,
                        input logic [31:0] d, input int lat);
    exp_t e;
    int start, n;
    bit ok = 0;
    n = w == 2'b00 ? 1 : w == 2'b01 ? 2 : 4;
    @(posedge clk);
    #1;
    re_MEM_i = !we;
    we_MEM_i = we;
    addr_MEM_i = a;
    width_MEM_i = w;
    data_MEM_i = d;
    start = cyc;
    e.data = 0;
    for (int k = 0; k < n; k++)
      if (we) ref_mem[(a + k) & MASK] = d[8*k +: 8];
      else e.data[8*k +: 8] = ref_mem[(a + k) & MASK];
    e.chk_data = !we;
    e.at = lat < 0 ? -1 : start + lat;
    q_mem.push_back(e);
    @(negedge clk);
    chk("stall_pending", 32'(stall_STALLER_o), 1);
    repeat (200) begin
      @(negedge clk);
      if (done_MEM_o) begin
        ok = 1;
        break;
      end
    end
    chk("mem_done_seen", 32'(ok), 1);
    chk("stall_at_done", 32'(stall_STALLER_o), 0);
    @(posedge clk);
    #1;
    re_MEM_i = 0;
    we_MEM_i = 0;
  endtask

  task automatic sim_pair();
    bit mf;
`ifdef ARB_ROUNDROBIN_EN
    mf = !last_mem;
`else
    mf = 1;
`endif
    fork
      ic_fill(32'h1000, mf ? 13 : 6);
      mem_op(0, 32'h2004, 2'b10, 0, mf ? 6 : 13);
    join
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] dv;
    int dones;
    for (int i = 0; i <= MASK; i++) ref_mem[i] = init_byte(i);
    repeat (3) @(negedge clk);
    chk("rst_ram_a", 32'(ram_a_o), 0);
    chk("rst_ram_wr", 32'(ram_wr_o), 0);
    chk("rst_done", {30'b0, done_ICACHE_o, done_MEM_o}, 0);
    chk("rst_data_ic", data_ICACHE_o, 0);
    chk("rst_data_mem", data_MEM_o, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    fork
      ic_fill(32'h1000, 6);
      begin
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("ic_addr", 32'(ram_a_o), 32'h1000 + k);
          chk("ic_rd", {31'b0, ram_wr_o}, 0);
          chk("ic_stall", {31'b0, stall_STALLER_o}, 0);
        end
      end
    join

    dv = 32'hDEADBEEF;
    fork
      mem_op(1, 32'h2004, 2'b10, dv, 5);
      begin
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("st_addr", 32'(ram_a_o), 32'h2004 + k);
          chk("st_wr", {31'b0, ram_wr_o}, 1);
          chk("st_dout", {24'b0, ram_dout_o}, {24'b0, dv[8*k +: 8]});
        end
      end
    join
    mem_op(0, 32'h2005, 2'b00, 0, 3);
    mem_op(0, 32'h2006, 2'b01, 0, 4);

    sim_pair();
    ic_fill(32'h1000, 6);
    sim_pair();

    fork
      mem_op(0, 32'h0001FFFE, 2'b10, 0, 6);
      begin
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("wrap_addr", 32'(ram_a_o), (32'h1FFFE + k) & MASK);
        end
      end
    join

    @(posedge clk);
    #1;
    we_MEM_i = 1;
    addr_MEM_i = 32'h2100;
    width_MEM_i = 2'b10;
    data_MEM_i = 32'hCAFEF00D;
    ref_mem[32'h2100] = 8'h0D;
    ref_mem[32'h2101] = 8'hF0;
    repeat (4) @(negedge clk);
    chk("rst_beat2_addr", 32'(ram_a_o), 32'h2102);
    rst_n = 0;
    #1;
    chk("arst_ram_a", 32'(ram_a_o), 0);
    chk("arst_ram_wr", {31'b0, ram_wr_o}, 0);
    chk("arst_dout", {24'b0, ram_dout_o}, 0);
    chk("arst_done", {30'b0, done_ICACHE_o, done_MEM_o}, 0);
    chk("arst_data", data_ICACHE_o | data_MEM_o, 0);
    we_MEM_i = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      dones += int'(done_ICACHE_o) + int'(done_MEM_o);
    end
    chk("no_done_after_rst", 32'(dones), 0);
    ic_fill(32'h1000, 6);

    fork
      repeat (30) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        ic_fill(32'h1000 + 4 * $urandom_range(0, 1023), -1);
      end
      repeat (50) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        mem_op(1'($urandom_range(0, 1)), 32'h2200 + $urandom_range(0, 255),
               2'($urandom_range(0, 3)), $urandom, -1);
      end
    join

    repeat (5) @(negedge clk);
    chk("ic_queue_empty", 32'(q_ic.size()), 0);
    chk("mem_queue_empty", 32'(q_mem.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
